// File: rtl/mod_counter_ctrl_if.sv
// Control/status bundle for mod_counter_ctrl.
// roll_cnt exists only when MOD_COUNTER_ROLL_CNT_EN is defined.
interface mod_counter_ctrl_if #(
  parameter int WIDTH = 7
`ifdef MOD_COUNTER_ROLL_CNT_EN
  , parameter int RCNT_WIDTH = 8
`endif
);
  logic             en;
  logic             start;
  logic             clear;
  logic             oneshot;
  logic             up;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] count;
  logic             roll;
  logic             busy;
  logic             done;
`ifdef MOD_COUNTER_ROLL_CNT_EN
  logic [RCNT_WIDTH-1:0] roll_cnt;

  modport master (output en, start, clear, oneshot, up, max_val,
                  input  count, roll, busy, done, roll_cnt);
  modport slave  (input  en, start, clear, oneshot, up, max_val,
                  output count, roll, busy, done, roll_cnt);
`else
  modport master (output en, start, clear, oneshot, up, max_val,
                  input  count, roll, busy, done);
  modport slave  (input  en, start, clear, oneshot, up, max_val,
                  output count, roll, busy, done);
`endif
endinterface

// File: rtl/mod_counter_ctrl.sv
// Runtime-modulus up/down counter with one-shot/free-run modes for ADC sample timing.
// Optional saturating roll event counter enabled by MOD_COUNTER_ROLL_CNT_EN.
//
// state  | meaning
// IDLE   | stopped, count held, busy=0 done=0
// RUN    | counting while en=1, busy=1
// DONE   | one-shot reached terminal, count held, done=1
module mod_counter_ctrl #(
  parameter int WIDTH      = 7,
  parameter bit AUTO_START = 1'b1
`ifdef MOD_COUNTER_ROLL_CNT_EN
  , parameter int RCNT_WIDTH = 8
`endif
) (
  input logic               clk,
  input logic               reset,
  mod_counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             at_term;
  logic [WIDTH-1:0] start_val;
  logic             roll;

  always_comb begin
    // >= rather than == so a max_val lowered below count still terminates
    at_term   = bus.up ? (count_q >= bus.max_val) : (count_q == '0);
    start_val = bus.up ? '0 : bus.max_val;
    roll      = (state_q == S_RUN) && bus.en && at_term;
    state_d   = state_q;
    count_d   = count_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (bus.start) begin
      state_d = S_RUN;
      count_d = start_val;
    end else if ((state_q == S_RUN) && bus.en) begin
      if (!at_term) begin
        count_d = bus.up ? (count_q + 1'b1) : (count_q - 1'b1);
      end else if (bus.oneshot) begin
        state_d = S_DONE;
      end else begin
        count_d = start_val;
      end
    end
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= AUTO_START ? S_RUN : S_IDLE;
      count_q <= '0;
      busy_q  <= AUTO_START;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.roll  = roll;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef MOD_COUNTER_ROLL_CNT_EN
  logic [RCNT_WIDTH-1:0] roll_cnt_q, roll_cnt_d;

  always_comb begin
    roll_cnt_d = roll_cnt_q;
    if (bus.clear || bus.start) begin
      roll_cnt_d = '0;
    end else if (roll && (roll_cnt_q != '1)) begin
      roll_cnt_d = roll_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roll_cnt_q <= '0;
    end else begin
      roll_cnt_q <= roll_cnt_d;
    end
  end

  assign bus.roll_cnt = roll_cnt_q;
`endif

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Randomised and directed checks of mod_counter_ctrl against a behavioural model.
// Two instances: AUTO_START=1 (a) and AUTO_START=0 (b), sharing the same inputs.
module tb_mod_counter_ctrl;
  localparam int W = 7;
  localparam int R = 2;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2;

  logic clk, reset;
  logic en, start, clear, oneshot, up;
  logic [W-1:0] max_val;

  int total, bad;
  int m_state[2];
  int m_count[2];
  int m_rcnt[2];

`ifdef MOD_COUNTER_ROLL_CNT_EN
  mod_counter_ctrl_if #(.WIDTH(W), .RCNT_WIDTH(R)) if_a();
  mod_counter_ctrl_if #(.WIDTH(W), .RCNT_WIDTH(R)) if_b();
  mod_counter_ctrl #(.WIDTH(W), .AUTO_START(1'b1), .RCNT_WIDTH(R)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  mod_counter_ctrl #(.WIDTH(W), .AUTO_START(1'b0), .RCNT_WIDTH(R)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
`else
  mod_counter_ctrl_if #(.WIDTH(W)) if_a();
  mod_counter_ctrl_if #(.WIDTH(W)) if_b();
  mod_counter_ctrl #(.WIDTH(W), .AUTO_START(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  mod_counter_ctrl #(.WIDTH(W), .AUTO_START(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
`endif

  assign if_a.en = en;       assign if_b.en = en;
  assign if_a.start = start; assign if_b.start = start;
  assign if_a.clear = clear; assign if_b.clear = clear;
  assign if_a.oneshot = oneshot; assign if_b.oneshot = oneshot;
  assign if_a.up = up;       assign if_b.up = up;
  assign if_a.max_val = max_val; assign if_b.max_val = max_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (actual=running required=finished)");
    $fatal(1);
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = (k == 0) ? ST_RUN : ST_IDLE;
      m_count[k] = 0;
      m_rcnt[k]  = 0;
    end
  endtask

  function automatic int m_term(input int k);
    if (up) return (m_count[k] >= int'(max_val)) ? 1 : 0;
    return (m_count[k] == 0) ? 1 : 0;
  endfunction

  function automatic int m_roll(input int k);
    return (m_state[k] == ST_RUN && en && m_term(k) == 1) ? 1 : 0;
  endfunction

  task automatic model_step();
    int reload, rl, tm;
    for (int k = 0; k < 2; k++) begin
      reload = up ? 0 : int'(max_val);
      rl = m_roll(k);
      tm = m_term(k);
      if (clear) begin
        m_state[k] = ST_IDLE; m_count[k] = 0; m_rcnt[k] = 0;
      end else if (start) begin
        m_state[k] = ST_RUN; m_count[k] = reload; m_rcnt[k] = 0;
      end else begin
        if (rl == 1 && m_rcnt[k] < (1 << R) - 1) m_rcnt[k] = m_rcnt[k] + 1;
        if (m_state[k] == ST_RUN && en) begin
          if (tm == 0) m_count[k] = up ? m_count[k] + 1 : m_count[k] - 1;
          else if (oneshot) m_state[k] = ST_DONE;
          else m_count[k] = reload;
        end
      end
    end
  endtask

  // compare both instances against the model, 1 time unit after inputs settle
  task automatic chk();
    #1;
    cmp("a.count", int'(if_a.count), m_count[0]);
    cmp("a.roll",  int'(if_a.roll),  m_roll(0));
    cmp("a.busy",  int'(if_a.busy),  (m_state[0] == ST_RUN) ? 1 : 0);
    cmp("a.done",  int'(if_a.done),  (m_state[0] == ST_DONE) ? 1 : 0);
    cmp("b.count", int'(if_b.count), m_count[1]);
    cmp("b.roll",  int'(if_b.roll),  m_roll(1));
    cmp("b.busy",  int'(if_b.busy),  (m_state[1] == ST_RUN) ? 1 : 0);
    cmp("b.done",  int'(if_b.done),  (m_state[1] == ST_DONE) ? 1 : 0);
`ifdef MOD_COUNTER_ROLL_CNT_EN
    cmp("a.roll_cnt", int'(if_a.roll_cnt), m_rcnt[0]);
    cmp("b.roll_cnt", int'(if_b.roll_cnt), m_rcnt[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
  endtask

  int t3[6];

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; en = 1'b1; up = 1'b1; oneshot = 1'b0; max_val = 7'd127;
    start = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk();
    cmp("rst a.count", int'(if_a.count), 0);
    cmp("rst a.busy", int'(if_a.busy), 1);
    cmp("rst b.busy", int'(if_b.busy), 0);
    cmp("rst b.done", int'(if_b.done), 0);

    // legacy roll counter: 0..127 then wrap
    for (int i = 0; i < 131; i++) begin
      chk();
      cmp("t1 count", int'(if_a.count), i % 128);
      cmp("t1 roll", int'(if_a.roll), (i % 128 == 127) ? 1 : 0);
      tick();
    end
    for (int i = 0; i < 200 && m_count[0] != 50; i++) tick();
    cmp("t1 reach50", int'(if_a.count), 50);
    reset = 1'b1;
    model_reset();
    #1;
    cmp("async rst count", int'(if_a.count), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk();

    // one-shot on instance b
    oneshot = 1'b1; max_val = 7'd5; start = 1'b1;
    chk(); tick(); start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      chk();
      cmp("t2 count", int'(if_b.count), i);
      cmp("t2 roll", int'(if_b.roll), (i == 5) ? 1 : 0);
      cmp("t2 busy", int'(if_b.busy), 1);
      tick();
    end
    chk();
    cmp("t2 done", int'(if_b.done), 1);
    cmp("t2 busy off", int'(if_b.busy), 0);
    tick(); chk();
    cmp("t2 hold", int'(if_b.count), 5);
    start = 1'b1; chk(); tick(); start = 1'b0; chk();
    cmp("t2 restart count", int'(if_b.count), 0);
    cmp("t2 restart busy", int'(if_b.busy), 1);

    // down free-run
    oneshot = 1'b0; up = 1'b0; max_val = 7'd3; start = 1'b1;
    chk(); tick(); start = 1'b0;
    t3 = '{3, 2, 1, 0, 3, 2};
    for (int i = 0; i < 6; i++) begin
      chk();
      cmp("t3 count", int'(if_b.count), t3[i]);
      cmp("t3 roll", int'(if_b.roll), (t3[i] == 0) ? 1 : 0);
      tick();
    end

    // lowering max_val below count
    up = 1'b1; max_val = 7'd10; start = 1'b1;
    chk(); tick(); start = 1'b0;
    repeat (7) begin chk(); tick(); end
    chk();
    cmp("t4 count7", int'(if_b.count), 7);
    max_val = 7'd4;
    chk();
    cmp("t4 roll", int'(if_b.roll), 1);
    tick(); chk();
    cmp("t4 wrap", int'(if_b.count), 0);

    // en toggling, then start+clear together
    max_val = 7'd100; start = 1'b1;
    chk(); tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = (i % 2 == 0);
      chk();
      cmp("t5 count", int'(if_b.count), (i + 1) / 2);
      tick();
    end
    en = 1'b1; start = 1'b1; clear = 1'b1;
    chk(); tick(); start = 1'b0; clear = 1'b0; chk();
    cmp("t5 a.count", int'(if_a.count), 0);
    cmp("t5 a.busy", int'(if_a.busy), 0);
    cmp("t5 b.busy", int'(if_b.busy), 0);

`ifdef MOD_COUNTER_ROLL_CNT_EN
    max_val = 7'd1; start = 1'b1;
    chk(); tick(); start = 1'b0;
    repeat (10) begin chk(); tick(); end
    chk();
    cmp("t6 saturate", int'(if_b.roll_cnt), 3);
    clear = 1'b1; chk(); tick(); clear = 1'b0; chk();
    cmp("t6 cleared", int'(if_b.roll_cnt), 0);
`endif

    // randomised phase
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) begin
        reset = 1'b1;
        model_reset();
        chk();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
      en      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      oneshot = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       max_val = 7'd0;
        1:       max_val = 7'd127;
        2:       max_val = 7'($urandom_range(0, 127));
        default: max_val = 7'($urandom_range(1, 12));
      endcase
      if ($urandom_range(0, 7) != 0 && i > 0) max_val = max_val; // stays random each cycle
      start = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 59) == 0);
      chk();
      tick();
    end
    start = 1'b0; clear = 1'b0;
    chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
